// File: rtl/transport_checksum_inserter.sv
// Buffers frames in two ping-pong banks, then replays them on AXI-Stream with the transport checksum patched in.
// Optional live statistics counters: define TRANSPORT_CHECKSUM_INSERTER_STATS_EN.
module transport_checksum_inserter #(
    parameter int unsigned MAX_FRAME_BYTES = 2048,
    parameter int unsigned AW              = $clog2(MAX_FRAME_BYTES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    input  logic [15:0] chk_value,
    input  logic [15:0] chk_orig,
    input  logic [15:0] chk_pos,
    input  logic        chk_done,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] frames_out,
    output logic [31:0] frames_dropped,
    output logic [31:0] csum_mismatch
);

    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {BK_EMPTY, BK_WAIT, BK_READY} bank_st_e;
    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_STREAM} rd_st_e;

    typedef struct packed {
        logic [LW-1:0] len;
        logic          trunc;
        logic [15:0]   value;
        logic [15:0]   pos;
    } desc_t;

    logic [7:0]  mem [2*MAX_FRAME_BYTES];
    bank_st_e    bank_st_q [2];
    desc_t       desc_q [2];
    logic        wbank_q, rbank_q;
    logic [LW-1:0] wr_idx_q;
    logic        wr_skip_q, wr_trunc_q;
    rd_st_e      rd_st_q;
    logic [AW-1:0] rd_idx_q;
    logic [7:0]  tdata_q;
    logic        tlast_q, tvalid_q;

    // Write side: the byte in a chk_done cycle is discarded like upstream does.
    logic        in_v_c, accept_c, fits_c, mem_we_c, drop_wr_c;
    logic [AW:0] waddr_c;

    assign in_v_c    = s_axis_tvalid & ~chk_done;
    assign accept_c  = in_v_c & ~wr_skip_q &
                       ((wr_idx_q != '0) | (bank_st_q[wbank_q] == BK_EMPTY));
    assign fits_c    = wr_idx_q < LW'(MAX_FRAME_BYTES);
    assign mem_we_c  = accept_c & fits_c;
    assign waddr_c   = {wbank_q, wr_idx_q[AW-1:0]};
    assign drop_wr_c = in_v_c & ~accept_c & s_axis_tlast;

    // Checksum latch targets whichever bank is waiting (never more than one).
    logic chk_hit_c, chk_bank_c, chk_drop_c;

    assign chk_hit_c  = chk_done & ((bank_st_q[0] == BK_WAIT) | (bank_st_q[1] == BK_WAIT));
    assign chk_bank_c = (bank_st_q[0] == BK_WAIT) ? 1'b0 : 1'b1;
    assign chk_drop_c = chk_hit_c & desc_q[chk_bank_c].trunc;

    // Read side: the output register doubles as the synchronous memory read register.
    desc_t         rdesc_c;
    logic          hs_c, release_c, load_c, last_c, patch_en_c;
    logic [AW-1:0] rd_addr_c;
    logic [15:0]   addr16_c;
    logic [7:0]    rd_byte_c;

    assign rdesc_c    = desc_q[rbank_q];
    assign hs_c       = tvalid_q & m_axis_tready;
    assign release_c  = (rd_st_q == RD_STREAM) & hs_c & tlast_q;
    assign load_c     = (rd_st_q == RD_FETCH) | ((rd_st_q == RD_STREAM) & hs_c & ~tlast_q);
    assign rd_addr_c  = (rd_st_q == RD_FETCH) ? rd_idx_q : rd_idx_q + AW'(1);
    assign addr16_c   = 16'(rd_addr_c);
    assign last_c     = LW'(rd_addr_c) == (rdesc_c.len - LW'(1));
    assign patch_en_c = (rdesc_c.value != 16'd0) & (32'(rdesc_c.pos) < 32'(rdesc_c.len));

    always_comb begin
        rd_byte_c = mem[{rbank_q, rd_addr_c}];
        if (patch_en_c && (addr16_c == (rdesc_c.pos - 16'd1))) begin
            rd_byte_c = rdesc_c.value[7:0];
        end else if (patch_en_c && (addr16_c == rdesc_c.pos)) begin
            rd_byte_c = rdesc_c.value[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[waddr_c] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tdata_q <= 8'd0;
        end else if (load_c) begin
            tdata_q <= rd_byte_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_st_q[b] <= BK_EMPTY;
                desc_q[b]    <= '0;
            end
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            wr_idx_q   <= '0;
            wr_skip_q  <= 1'b0;
            wr_trunc_q <= 1'b0;
            rd_st_q    <= RD_IDLE;
            rd_idx_q   <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            if (in_v_c) begin
                if (s_axis_tlast) begin
                    wr_idx_q   <= '0;
                    wr_skip_q  <= 1'b0;
                    wr_trunc_q <= 1'b0;
                    if (accept_c) begin
                        desc_q[wbank_q].len   <= wr_idx_q + LW'(1);
                        desc_q[wbank_q].trunc <= wr_trunc_q | ~fits_c;
                        bank_st_q[wbank_q]    <= BK_WAIT;
                        wbank_q               <= ~wbank_q;
                    end
                end else if (!accept_c) begin
                    wr_skip_q <= 1'b1;
                end else if (fits_c) begin
                    wr_idx_q <= wr_idx_q + LW'(1);
                end else begin
                    wr_trunc_q <= 1'b1;
                end
            end

            // A dropped truncated frame hands its bank back to the writer so bank order stays aligned with rbank.
            if (chk_hit_c) begin
                desc_q[chk_bank_c].value <= chk_value;
                desc_q[chk_bank_c].pos   <= chk_pos;
                if (desc_q[chk_bank_c].trunc) begin
                    bank_st_q[chk_bank_c] <= BK_EMPTY;
                    wbank_q               <= chk_bank_c;
                end else begin
                    bank_st_q[chk_bank_c] <= BK_READY;
                end
            end

            case (rd_st_q)
                RD_IDLE: begin
                    if (bank_st_q[rbank_q] == BK_READY) begin
                        rd_st_q  <= RD_FETCH;
                        rd_idx_q <= '0;
                    end
                end
                RD_FETCH: begin
                    rd_st_q  <= RD_STREAM;
                    tvalid_q <= 1'b1;
                    tlast_q  <= last_c;
                end
                RD_STREAM: begin
                    if (hs_c) begin
                        if (tlast_q) begin
                            tvalid_q           <= 1'b0;
                            tlast_q            <= 1'b0;
                            bank_st_q[rbank_q] <= BK_EMPTY;
                            rbank_q            <= ~rbank_q;
                            rd_st_q            <= RD_IDLE;
                        end else begin
                            rd_idx_q <= rd_addr_c;
                            tlast_q  <= last_c;
                        end
                    end
                end
                default: rd_st_q <= RD_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;

`ifdef TRANSPORT_CHECKSUM_INSERTER_STATS_EN
    logic [31:0] frames_out_q, frames_dropped_q, csum_mismatch_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_out_q     <= 32'd0;
            frames_dropped_q <= 32'd0;
            csum_mismatch_q  <= 32'd0;
        end else begin
            if (release_c) begin
                frames_out_q <= frames_out_q + 32'd1;
            end
            frames_dropped_q <= frames_dropped_q + 32'(drop_wr_c) + 32'(chk_drop_c);
            if (chk_hit_c && (chk_value != 16'd0) && (chk_orig != chk_value)) begin
                csum_mismatch_q <= csum_mismatch_q + 32'd1;
            end
        end
    end

    assign frames_out     = frames_out_q;
    assign frames_dropped = frames_dropped_q;
    assign csum_mismatch  = csum_mismatch_q;
`else
    logic stats_unused_c;
    assign stats_unused_c = ^{chk_orig, drop_wr_c, chk_drop_c, release_c};

    assign frames_out     = 32'd0;
    assign frames_dropped = 32'd0;
    assign csum_mismatch  = 32'd0;
`endif

endmodule

// File: tb/tb_transport_checksum_inserter.sv
// Directed bench for transport_checksum_inserter: patching, pass-through, bank overflow, truncation, stalls, reset.
module tb_transport_checksum_inserter;

    localparam int MAXB = 2048;
`ifdef TRANSPORT_CHECKSUM_INSERTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tlast, s_axis_tvalid;
    logic [15:0] chk_value, chk_orig, chk_pos;
    logic        chk_done;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [31:0] frames_out, frames_dropped, csum_mismatch;

    int checks = 0;
    int failures = 0;
    int stall_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic [7:0] cap_data[$];
    logic       cap_last[$];
    logic [7:0] exp_data[$];
    logic       exp_last[$];

    transport_checksum_inserter dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .chk_value(chk_value), .chk_orig(chk_orig), .chk_pos(chk_pos), .chk_done(chk_done),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .frames_out(frames_out), .frames_dropped(frames_dropped), .csum_mismatch(csum_mismatch)
    );

    always #5 clk = ~clk;

    // Output beats and stall stability are observed mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_axis_tvalid || (m_axis_tdata !== prev_data))) stall_err++;
            if (m_axis_tvalid && m_axis_tready) begin
                cap_data.push_back(m_axis_tdata);
                cap_last.push_back(m_axis_tlast);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [7:0] pat(input int tag, input int i);
        int v;
        v = i * 3 + tag * 29 + (i >>> 8);
        return 8'(v);
    endfunction

    function automatic logic [31:0] cap_at(input int i);
        if (i < cap_data.size()) return 32'(cap_data[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic build_exp(input int tag, input int len, input logic [15:0] v, input int pos);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = pat(tag, i);
            if (v != 16'd0 && pos < len) begin
                if (i == pos - 1) b = v[7:0];
                if (i == pos)     b = v[15:8];
            end
            exp_data.push_back(b);
            exp_last.push_back(i == len - 1);
        end
    endtask

    task automatic send_frame(input int tag, input int len, input logic [15:0] v,
                              input logic [15:0] o, input logic [15:0] p);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #2;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pat(tag, i);
            s_axis_tlast  = (i == len - 1);
        end
        @(posedge clk); #2;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk_done      = 1'b1;
        chk_value     = v;
        chk_orig      = o;
        chk_pos       = p;
        @(posedge clk); #2;
        chk_done = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input bit random_ready);
        int cyc = 0;
        while (cap_data.size() < n && cyc < budget) begin
            @(posedge clk); #2;
            if (random_ready) m_axis_tready = 1'($urandom_range(0, 1));
            cyc++;
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic check_output(input string name);
        int derr = 0;
        int lerr = 0;
        int n;
        check({name, "_len"}, 32'(cap_data.size()), 32'(exp_data.size()));
        n = (cap_data.size() < exp_data.size()) ? cap_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            if (cap_data[i] !== exp_data[i]) derr++;
            if (cap_last[i] !== exp_last[i]) lerr++;
        end
        check({name, "_data"}, 32'(derr), 32'd0);
        check({name, "_tlast"}, 32'(lerr), 32'd0);
    endtask

    task automatic clear_q();
        cap_data.delete(); cap_last.delete();
        exp_data.delete(); exp_last.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        s_axis_tdata = 8'd0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        chk_value = 16'd0; chk_orig = 16'd0; chk_pos = 16'd0; chk_done = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_frames_out", frames_out, 32'd0);
        check("rst_dropped", frames_dropped, 32'd0);
        check("rst_mismatch", csum_mismatch, 32'd0);

        // 60-byte UDP frame patched at bytes 40/41
        m_axis_tready = 1'b1;
        build_exp(1, 60, 16'hBEEF, 41);
        send_frame(1, 60, 16'hBEEF, 16'h0000, 16'd41);
        wait_beats(60, 500, 1'b0);
        idle(3);
        check_output("t1");
        check("t1_byte40", cap_at(40), 32'h0000_00EF);
        check("t1_byte41", cap_at(41), 32'h0000_00BE);
        check("t1_byte39", cap_at(39), 32'(pat(1, 39)));
        check("t1_mismatch", csum_mismatch, exp_cnt(1));
        check("t1_frames_out", frames_out, exp_cnt(1));
        clear_q();

        // checksum 0: verbatim pass-through, no mismatch counted
        build_exp(2, 64, 16'h0000, 41);
        send_frame(2, 64, 16'h0000, 16'h1234, 16'd41);
        wait_beats(64, 500, 1'b0);
        idle(3);
        check_output("t2");
        check("t2_byte40", cap_at(40), 32'(pat(2, 40)));
        check("t2_mismatch", csum_mismatch, exp_cnt(1));
        check("t2_frames_out", frames_out, exp_cnt(2));
        clear_q();

        // three frames against a stalled sink: third finds both banks full
        m_axis_tready = 1'b0;
        send_frame(3, 100, 16'h0000, 16'h0000, 16'd0);
        send_frame(4, 100, 16'h0000, 16'h0000, 16'd0);
        send_frame(5, 100, 16'h0000, 16'h0000, 16'd0);
        idle(5);
        check("t3_held_beats", 32'(cap_data.size()), 32'd0);
        check("t3_valid_stalled", 32'(m_axis_tvalid), 32'd1);
        check("t3_dropped", frames_dropped, exp_cnt(1));
        build_exp(3, 100, 16'h0000, 0);
        build_exp(4, 100, 16'h0000, 0);
        m_axis_tready = 1'b1;
        wait_beats(200, 2000, 1'b0);
        idle(5);
        check_output("t3");
        check("t3_frames_out", frames_out, exp_cnt(4));
        clear_q();

        // 1500-byte TCP frame drained with random backpressure
        m_axis_tready = 1'b0;
        build_exp(6, 1500, 16'h1A2B, 51);
        send_frame(6, 1500, 16'h1A2B, 16'h1A2B, 16'd51);
        wait_beats(1500, 20000, 1'b1);
        idle(3);
        check_output("t4");
        check("t4_byte50", cap_at(50), 32'h0000_002B);
        check("t4_byte51", cap_at(51), 32'h0000_001A);
        check("t4_stall_stable", 32'(stall_err), 32'd0);
        check("t4_mismatch", csum_mismatch, exp_cnt(1));
        check("t4_frames_out", frames_out, exp_cnt(5));
        clear_q();

        // oversize frame is discarded; the following frame flows normally
        send_frame(7, MAXB + 10, 16'h0000, 16'h0000, 16'd0);
        idle(20);
        check("t5_not_emitted", 32'(cap_data.size()), 32'd0);
        check("t5_dropped", frames_dropped, exp_cnt(2));
        build_exp(8, 70, 16'h0102, 10);
        send_frame(8, 70, 16'h0102, 16'h0000, 16'd10);
        wait_beats(70, 500, 1'b0);
        idle(3);
        check_output("t5b");
        check("t5b_byte9", cap_at(9), 32'h0000_0002);
        check("t5b_byte10", cap_at(10), 32'h0000_0001);
        check("t5b_frames_out", frames_out, exp_cnt(6));
        check("t5b_mismatch", csum_mismatch, exp_cnt(2));
        clear_q();

        // one-cycle reset while a frame is stalled mid-stream
        m_axis_tready = 1'b0;
        send_frame(9, 80, 16'h0000, 16'h0000, 16'd0);
        idle(5);
        check("t6_pre_valid", 32'(m_axis_tvalid), 32'd1);
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", 32'(m_axis_tvalid), 32'd0);
        check("t6_rst_frames_out", frames_out, 32'd0);
        check("t6_rst_dropped", frames_dropped, 32'd0);
        check("t6_rst_mismatch", csum_mismatch, 32'd0);
        clear_q();
        m_axis_tready = 1'b1;
        build_exp(10, 40, 16'h5566, 30);
        send_frame(10, 40, 16'h5566, 16'h0000, 16'd30);
        wait_beats(40, 500, 1'b0);
        idle(3);
        check_output("t6");
        check("t6_byte29", cap_at(29), 32'h0000_0066);
        check("t6_byte30", cap_at(30), 32'h0000_0055);
        check("t6_frames_out", frames_out, exp_cnt(1));
        check("t6_mismatch", csum_mismatch, exp_cnt(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
